// File: rtl/dmem_arbiter.sv
// Data-memory port arbiter between the core M-stage and an external requester.
// The core normally wins; a starvation counter periodically forces one external access.
module dmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  localparam logic [0:0] CORE_PRI  = 1'b0;
  localparam logic [0:0] EXT_FORCE = 1'b1;

  logic [0:0]        r_state;
  logic [CNT_W-1:0]  r_wait_cnt;
  logic              r_ext_rvalid;
  logic [DATA_W-1:0] r_ext_rdata;

  logic w_conflict;
  assign w_conflict = core_req & ext_req;

  assign core_rdata = mem_rdata;

  // A read response still in flight is hidden as soon as reset is asserted.
  assign ext_rvalid = r_ext_rvalid & reset;
  assign ext_rdata  = reset ? r_ext_rdata : '0;

  always_comb begin
    // NOTE: every output gets a default first so no path through the block infers a latch.
    mem_we     = 1'b0;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    ext_gnt    = 1'b0;
    core_stall = 1'b0;
    if (!reset) begin
      mem_addr  = '0;
      mem_wdata = '0;
    end else if (r_state == EXT_FORCE) begin
      if (ext_req) begin
        ext_gnt    = 1'b1;
        mem_we     = ext_we;
        mem_addr   = ext_addr;
        mem_wdata  = ext_wdata;
        core_stall = core_req;
      end
    end else if (core_req) begin
      mem_we = core_we;
    end else if (ext_req) begin
      ext_gnt   = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= CORE_PRI;
      r_wait_cnt   <= '0;
      r_ext_rvalid <= 1'b0;
      r_ext_rdata  <= '0;
    end else begin
      r_ext_rvalid <= ext_gnt & ~ext_we;
      if (ext_gnt && !ext_we) begin
        r_ext_rdata <= mem_rdata;
      end

      if (r_state == EXT_FORCE) begin
        r_state    <= CORE_PRI;
        r_wait_cnt <= '0;
      end else if (w_conflict) begin
        if (r_wait_cnt == CNT_LAST) begin
          r_state    <= EXT_FORCE;
          r_wait_cnt <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 1'b1;
        end
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: reset, external/core-only traffic,
// starvation forcing, counter restart and reset during a read response.
module tb_dmem_arbiter;

  localparam int ADDR_W   = 14;
  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              clk;
  logic              reset;
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic [DATA_W-1:0] core_rdata;
  logic              core_stall;
  logic              ext_req;
  logic              ext_we;
  logic [ADDR_W-1:0] ext_addr;
  logic [DATA_W-1:0] ext_wdata;
  logic              ext_gnt;
  logic [DATA_W-1:0] ext_rdata;
  logic              ext_rvalid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] tb_mem [0:4095];

  dmem_arbiter #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .MAX_WAIT(MAX_WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .core_req  (core_req),
    .core_we   (core_we),
    .core_addr (core_addr),
    .core_wdata(core_wdata),
    .core_rdata(core_rdata),
    .core_stall(core_stall),
    .ext_req   (ext_req),
    .ext_we    (ext_we),
    .ext_addr  (ext_addr),
    .ext_wdata (ext_wdata),
    .ext_gnt   (ext_gnt),
    .ext_rdata (ext_rdata),
    .ext_rvalid(ext_rvalid),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Word-addressed memory model with combinational read.
  assign mem_rdata = tb_mem[mem_addr[ADDR_W-1:2]];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[ADDR_W-1:2]] <= mem_wdata;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset      = 1'b0;
    core_req   = 1'b1;
    core_we    = 1'b0;
    core_addr  = 14'h040;
    core_wdata = 32'h1111_1111;
    ext_req    = 1'b1;
    ext_we     = 1'b1;
    ext_addr   = 14'h080;
    ext_wdata  = 32'h2222_2222;
    #1;

    // Reset held with both sides requesting: all controls quiet.
    for (int i = 0; i < 3; i++) begin
      check("rst_mem_we", 32'(mem_we), 32'd0);
      check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
      check("rst_core_stall", 32'(core_stall), 32'd0);
      check("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
      check("rst_mem_addr", 32'(mem_addr), 32'd0);
      next_cycle();
    end

    // Release: core owns the port in CORE_PRI.
    reset = 1'b1;
    #1;
    check("rel_mem_addr", 32'(mem_addr), 32'h040);
    check("rel_ext_gnt", 32'(ext_gnt), 32'd0);
    check("rel_core_stall", 32'(core_stall), 32'd0);
    next_cycle();

    // External-only writes.
    core_req  = 1'b0;
    ext_req   = 1'b1;
    ext_we    = 1'b1;
    ext_addr  = 14'h010;
    ext_wdata = 32'hDEAD_BEEF;
    #1;
    check("extw_gnt", 32'(ext_gnt), 32'd1);
    check("extw_mem_we", 32'(mem_we), 32'd1);
    check("extw_mem_addr", 32'(mem_addr), 32'h010);
    check("extw_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    next_cycle();
    ext_addr  = 14'h020;
    ext_wdata = 32'h1234_5678;
    #1;
    check("extw2_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();

    // External read of 0x010, response one cycle after grant.
    ext_we   = 1'b0;
    ext_addr = 14'h010;
    #1;
    check("extr_gnt", 32'(ext_gnt), 32'd1);
    check("extr_mem_we", 32'(mem_we), 32'd0);
    check("extr_rvalid_early", 32'(ext_rvalid), 32'd0);
    next_cycle();
    check("extr_rvalid", 32'(ext_rvalid), 32'd1);
    check("extr_rdata", ext_rdata, 32'hDEAD_BEEF);
    ext_req = 1'b0;
    next_cycle();
    check("extr_rvalid_pulse", 32'(ext_rvalid), 32'd0);

    // Core-only load of 0x020.
    core_req  = 1'b1;
    core_we   = 1'b0;
    core_addr = 14'h020;
    #1;
    check("core_rdata", core_rdata, 32'h1234_5678);
    check("core_stall0", 32'(core_stall), 32'd0);
    check("core_ext_gnt0", 32'(ext_gnt), 32'd0);
    next_cycle();

    // Continuous conflict: forced external grant at cycles 4 and 9.
    ext_req   = 1'b1;
    ext_we    = 1'b1;
    ext_addr  = 14'h100;
    ext_wdata = 32'hA5A5_A5A5;
    for (int c = 0; c < 10; c++) begin
      #1;
      if (c == 4 || c == 9) begin
        check("cf_gnt_forced", 32'(ext_gnt), 32'd1);
        check("cf_stall_forced", 32'(core_stall), 32'd1);
        check("cf_addr_forced", 32'(mem_addr), 32'h100);
        check("cf_we_forced", 32'(mem_we), 32'd1);
      end else begin
        check("cf_gnt_core", 32'(ext_gnt), 32'd0);
        check("cf_stall_core", 32'(core_stall), 32'd0);
        check("cf_addr_core", 32'(mem_addr), 32'h020);
        check("cf_we_core", 32'(mem_we), 32'd0);
      end
      next_cycle();
    end

    // Two conflict cycles, one idle ext cycle, then re-assert: counter restarts.
    for (int c = 0; c < 2; c++) begin
      #1;
      check("rs_pre_gnt", 32'(ext_gnt), 32'd0);
      next_cycle();
    end
    ext_req = 1'b0;
    #1;
    check("rs_drop_gnt", 32'(ext_gnt), 32'd0);
    next_cycle();
    ext_req = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("rs_gnt", 32'(ext_gnt), (c == 4) ? 32'd1 : 32'd0);
      check("rs_stall", 32'(core_stall), (c == 4) ? 32'd1 : 32'd0);
      next_cycle();
    end

    // External read granted, then reset asserted the next cycle.
    core_req = 1'b0;
    ext_we   = 1'b0;
    ext_addr = 14'h010;
    #1;
    check("rr_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    reset   = 1'b0;
    ext_req = 1'b0;
    #1;
    check("rr_rvalid_n1", 32'(ext_rvalid), 32'd0);
    check("rr_rdata_n1", ext_rdata, 32'd0);
    next_cycle();
    check("rr_rvalid_n2", 32'(ext_rvalid), 32'd0);
    check("rr_rdata_n2", ext_rdata, 32'd0);
    reset = 1'b1;
    next_cycle();
    check("rr_rvalid_after", 32'(ext_rvalid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Arbitrates the single data-memory port between the pipelined core's M-stage and an external requester (UVM backdoor loader / debug master).
- Core has priority by default.
- A starvation counter forces one external access after MAX_WAIT consecutive conflict cycles and stalls the core for that cycle.
- Sits between the EX/MEM register outputs, the data memory and the hazard unit; core_stall feeds the hazard unit's global freeze.

Parameters:
ADDR_W, 14, data-memory byte address width
DATA_W, 32, data word width
MAX_WAIT, 4, conflict cycles before the external requester is forced through; legal range 1..15

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-low reset
core_req  in  1  M-stage memory access valid (load or store)
core_we  in  1  core store enable
core_addr  in  ADDR_W  core address (ALU result, M-stage)
core_wdata  in  DATA_W  core store data
core_rdata  out  DATA_W  core load data, combinational
core_stall  out  1  freeze pipeline this cycle
ext_req  in  1  external request valid
ext_we  in  1  external write enable
ext_addr  in  ADDR_W  external address
ext_wdata  in  DATA_W  external write data
ext_gnt  out  1  external transfer accepted this cycle
ext_rdata  out  DATA_W  external read data, registered
ext_rvalid  out  1  ext_rdata valid, one-cycle pulse
mem_we  out  1  to data memory, write enable
mem_addr  out  ADDR_W  to data memory, address
mem_wdata  out  DATA_W  to data memory, write data
mem_rdata  in  DATA_W  from data memory, combinational read

Behaviour:
- Reset:
  - Registered state: state=CORE_PRI, wait_cnt=0, ext_rvalid=0, ext_rdata=0.
  - While reset==0, combinational outputs are forced: mem_we=0, ext_gnt=0, core_stall=0, mem_addr=0, mem_wdata=0.
- wait_cnt width: $clog2(MAX_WAIT+1).
- Conflict: core_req & ext_req in the same cycle.
- State CORE_PRI:
  - core_req=1 → core owns port: mem_we=core_we, mem_addr=core_addr, mem_wdata=core_wdata; ext_gnt=0; core_stall=0.
  - core_req=0 & ext_req=1 → external owns port: ext_gnt=1, mem_*=ext_*; wait_cnt<=0.
  - Neither requesting → mem_we=0, mem_addr/mem_wdata hold core values; wait_cnt<=0.
  - Conflict with wait_cnt==MAX_WAIT-1 → state<=EXT_FORCE, wait_cnt<=0. Other conflicts → wait_cnt<=wait_cnt+1.
  - ext_req=0 in any cycle → wait_cnt<=0.
- State EXT_FORCE (always exactly one cycle, then state<=CORE_PRI):
  - ext_req=1 → ext_gnt=1, mem_*=ext_*, core_stall=core_req.
  - ext_req=0 (protocol violation) → mem_we=0, ext_gnt=0, core_stall=0.
- Core protocol:
  - While core_stall=1, core holds core_req/we/addr/wdata stable into the next cycle.
  - core_rdata=mem_rdata every cycle; it is meaningful only when core_req=1 & core_stall=0.
- External protocol:
  - ext_req and its payload stay stable until ext_gnt=1.
  - ext_req may be re-asserted, or held high for back-to-back transfers, in the cycle after a grant.
- External reads: on ext_gnt & ~ext_we, ext_rdata<=mem_rdata and ext_rvalid<=1 on the next edge; otherwise ext_rvalid<=0. Latency is exactly one cycle after the grant.
- External writes complete at the grant edge. No response pulse.
- A core store and an external access never reach memory in the same cycle: exactly one owner per cycle.
- Reset asserted mid-operation:
  - A pending ext_rvalid is suppressed (reads 0 next cycle).
  - A forced grant is cancelled.
  - The counter clears.
- Continuous conflict: external is granted every (MAX_WAIT+1)-th cycle, giving the core a throughput of MAX_WAIT/(MAX_WAIT+1).

Test Plan:
1. Reset low 3 cycles with core_req=ext_req=ext_we=1 → mem_we=0, ext_gnt=0, core_stall=0, ext_rvalid=0 each cycle. First edge after release: state CORE_PRI, core granted.
2. Ext-only traffic: write addr 0x010 data 0xDEADBEEF, then read 0x010 → ext_gnt=1 same cycle, mem_we=1 on write; read gives ext_rvalid=1 and ext_rdata=0xDEADBEEF one cycle after its grant.
3. Core-only load at 0x020 (preloaded 0x12345678) → core_rdata=0x12345678 same cycle, core_stall=0, ext_gnt=0.
4. MAX_WAIT=4, continuous conflict from cycle 0 (core loads, ext writes) → core owns cycles 0-3; cycle 4: ext_gnt=1, core_stall=1, mem_addr=ext_addr; cycle 5 core owns again; next forced grant at cycle 9.
5. Conflict for 2 cycles, ext_req dropped 1 cycle, then re-asserted with core_req high → wait_cnt restarts at 0; forced grant occurs 4 cycles after re-assertion, not 2.
6. Ext read granted at cycle N, reset low at cycle N+1 → ext_rvalid=0 at N+1 and N+2; ext_rdata=0.
